stepper_move_sequencer: RTL and testbench
=========================================

# stepper_move_sequencer

Command-driven move controller for the 4-coil unipolar stepper interface. It accepts move commands (direction, step count, step period) through a valid/ready handshake and paces the coil phase sequence with a programmable period counter. It tracks absolute position, holds torque for a settle interval after each move, and reports completion. It sits between the user-control logic (DIP/keypad decode) and the stepper driver pins, and replaces free-running per-clock stepping.

## Interface
- HOLD_CYCLES, 1000: cycles coils stay energized after the last step (settle time); 0 allowed.
- MIN_PERIOD, 2: smallest accepted step period in clocks; smaller cmd_period values are clamped up to it.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; transfer occurs when cmd_valid && cmd_ready.
- cmd_dir  in  1  1 = forward (phase index +1, position +1); 0 = reverse.
- cmd_steps  in  16  number of steps, unsigned.
- cmd_period  in  16  clocks per step, unsigned.
- abort  in  1  level; terminates a move in RUN or HOLD.
- stepmotor  out  4  coil drive pattern, registered.
- position  out  16  signed absolute step count, two's complement.
- busy  out  1  high in RUN and HOLD.
- done  out  1  one-cycle pulse in DONE.
- aborted  out  1  sticky until next accepted command; set when a move ended by abort.
- state  out  2  FSM encoding for LEDs: IDLE=00, RUN=01, HOLD=10, DONE=11.

## Operation
- FSM states: IDLE -> RUN on accept; RUN -> HOLD after the last step; HOLD -> DONE after HOLD_CYCLES; DONE -> IDLE unconditionally.
- Command capture:
  - On accept, latch dir, steps, and period (clamped).
  - Load the period counter and remaining = cmd_steps; clear aborted.
- cmd_steps = 0: accept goes RUN -> HOLD on the next cycle with no phase or position change.
- Step advance:
  - The period counter decrements every cycle in RUN.
  - On expiry: advance the phase index per dir, update position by ±1, decrement remaining, reload the counter.
- Phase index wraps modulo the table length in both directions. Position wraps modulo 2^16; no saturation.
- Full-step table, index 0..3: 1010, 0110, 0101, 1001.
- Phase index persists across moves, so the rotor never skips on restart. It is reset only by rst.
- stepmotor = table[index] while busy; 0000 in IDLE and DONE (coils de-energized).
- abort in RUN or HOLD:
  - Next state DONE, with aborted set and stepmotor 0000 from the following cycle.
  - Any step whose counter expires in the same cycle as abort is suppressed.
- abort in IDLE or DONE is ignored.
- cmd_valid in any state other than IDLE is not accepted; the command stays pending on the input.

## Timing
- Reset values:
  - stepmotor = 0000, position = 0, state = 00, busy = 0, done = 0, aborted = 0.
  - cmd_ready = 1 after reset deasserts.
  - Phase index = 0.
- Accept at edge k (period P, steps N ≥ 1):
  - From edge k: busy = 1, state = 01, stepmotor = table[index0].
  - The n-th step is applied at edge k + n·P, with both stepmotor and position updated at that edge.
  - HOLD from edge k + N·P; DONE at edge k + N·P + HOLD_CYCLES (done = 1 for one cycle).
  - IDLE and cmd_ready = 1 one edge later.
- Back-to-back commands: minimum spacing between accepts is N·P + HOLD_CYCLES + 2 cycles.
- Reset asserted mid-move: all outputs return to reset values immediately, without waiting for a clock.

## Configuration
- STEPPER_HALFSTEP_EN defined:
  - 8-entry half-step table, index 0..7: 1010, 0010, 0110, 0100, 0101, 0001, 1001, 1000.
  - Each step moves one half-step; position counts half-steps.
- Undefined: 4-entry full-step table above.
- Handshake, FSM, and timing are identical in both builds.

## Test plan
- Reset then forward move, steps = 5, period = 4, HOLD_CYCLES = 3:
  - stepmotor sequence 1010→0110→0101→1001→1010→0110, one change every 4 cycles.
  - position = 5; done pulse 23 cycles after accept; cmd_ready high the next cycle.
- Reverse move, steps = 3, period = 2, starting at index 0:
  - Patterns 1001, 0101, 0110.
  - position goes 0 → -3 (0xFFFD).
- Period = 0 and period = 1 commands: steps occur every 2 cycles (clamped to MIN_PERIOD).
- steps = 0: no stepmotor change and position unchanged; done occurs HOLD_CYCLES + 2 cycles after accept.
- Abort asserted on the same cycle as the 2nd step's counter expiry:
  - position = 1, aborted = 1, done pulse the next cycle, stepmotor = 0000.
  - Also check cmd_valid held during RUN is not accepted until IDLE.
- With STEPPER_HALFSTEP_EN, forward 8 steps: all 8 half-step patterns appear in order, and position = 8.

Source files
------------

// File: rtl/stepper_move_sequencer.sv
// stepper_move_sequencer
// Command-driven move controller for a 4-coil unipolar stepper. A move
// command (direction, step count, step period) is taken over a valid/ready
// handshake. The coil phase sequence is paced by a reloadable period counter.
// Absolute position is tracked, and torque is held for a settle interval
// after each move. Completion is reported with a one-cycle done pulse.
//
// Build option: define STEPPER_HALFSTEP_EN to select the 8-entry half-step
// table. Left undefined, the 4-entry full-step table is used and position
// counts full steps.
module stepper_move_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned MIN_PERIOD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_steps,
  input  logic [15:0] cmd_period,
  input  logic        abort,
  output logic [3:0]  stepmotor,
  output logic [15:0] position,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [1:0]  state
);

`ifdef STEPPER_HALFSTEP_EN
  localparam int PHASES = 8;
  localparam int IDX_W  = 3;
`else
  localparam int PHASES = 4;
  localparam int IDX_W  = 2;
`endif

  // The state encoding doubles as the LED code on the state output.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam logic [15:0] MIN_P     = 16'(MIN_PERIOD);
  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES);

  // Coil pattern for each phase index.
  function automatic logic [3:0] phase_pattern(input int idx);
    logic [3:0] pat;
    pat = 4'b0000;
`ifdef STEPPER_HALFSTEP_EN
    case (idx)
      0:       pat = 4'b1010;
      1:       pat = 4'b0010;
      2:       pat = 4'b0110;
      3:       pat = 4'b0100;
      4:       pat = 4'b0101;
      5:       pat = 4'b0001;
      6:       pat = 4'b1001;
      7:       pat = 4'b1000;
      default: pat = 4'b0000;
    endcase
`else
    case (idx)
      0:       pat = 4'b1010;
      1:       pat = 4'b0110;
      2:       pat = 4'b0101;
      3:       pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
`endif
    return pat;
  endfunction

  logic [3:0] phase_table [PHASES];

  generate
    for (genvar gi = 0; gi < PHASES; gi++) begin : g_table
      assign phase_table[gi] = phase_pattern(gi);
    end
  endgenerate

  logic [1:0]       state_reg,     state_next;
  logic [IDX_W-1:0] phase_reg,     phase_next;
  logic [15:0]      position_reg,  position_next;
  logic [15:0]      remaining_reg, remaining_next;
  logic [15:0]      period_reg,    period_next;
  logic [15:0]      per_cnt_reg,   per_cnt_next;
  logic [31:0]      hold_cnt_reg,  hold_cnt_next;
  logic             dir_reg,       dir_next;
  logic             aborted_reg,   aborted_next;
  logic [3:0]       stepmotor_reg, stepmotor_next;
  logic [15:0]      period_clamped;

  // Periods shorter than the driver can follow are raised to the minimum.
  assign period_clamped = (cmd_period < MIN_P) ? MIN_P : cmd_period;

  // Next-state logic: handshake, step pacing, hold timing and abort.
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    position_next  = position_reg;
    remaining_next = remaining_reg;
    period_next    = period_reg;
    per_cnt_next   = per_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    dir_next       = dir_reg;
    aborted_next   = aborted_reg;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next     = S_RUN;
          dir_next       = cmd_dir;
          period_next    = period_clamped;
          per_cnt_next   = period_clamped;
          remaining_next = cmd_steps;
          aborted_next   = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort wins over a step expiring in the same cycle.
          state_next   = S_DONE;
          aborted_next = 1'b1;
        end else if (remaining_reg == 16'd0) begin
          // Zero-step move: no motion, one extra settle cycle so done lands
          // HOLD_CYCLES + 2 after the accept.
          state_next    = S_HOLD;
          hold_cnt_next = HOLD_LOAD + 32'd1;
        end else if (per_cnt_reg <= 16'd1) begin
          phase_next     = dir_reg ? phase_reg + IDX_W'(1) : phase_reg - IDX_W'(1);
          position_next  = dir_reg ? position_reg + 16'd1 : position_reg - 16'd1;
          remaining_next = remaining_reg - 16'd1;
          per_cnt_next   = period_reg;
          if (remaining_reg == 16'd1) begin
            if (HOLD_CYCLES == 0) begin
              state_next = S_DONE;
            end else begin
              state_next    = S_HOLD;
              hold_cnt_next = HOLD_LOAD;
            end
          end
        end else begin
          per_cnt_next = per_cnt_reg - 16'd1;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_next   = S_DONE;
          aborted_next = 1'b1;
        end else if (hold_cnt_reg <= 32'd1) begin
          state_next = S_DONE;
        end else begin
          hold_cnt_next = hold_cnt_reg - 32'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Coils are energised only while the move is running or holding.
    if (state_next == S_RUN || state_next == S_HOLD) begin
      stepmotor_next = phase_table[phase_next];
    end else begin
      stepmotor_next = 4'b0000;
    end
  end

  // State registers; reset drops everything to idle with coils off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      phase_reg     <= '0;
      position_reg  <= 16'd0;
      remaining_reg <= 16'd0;
      period_reg    <= 16'd0;
      per_cnt_reg   <= 16'd0;
      hold_cnt_reg  <= 32'd0;
      dir_reg       <= 1'b0;
      aborted_reg   <= 1'b0;
      stepmotor_reg <= 4'b0000;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      position_reg  <= position_next;
      remaining_reg <= remaining_next;
      period_reg    <= period_next;
      per_cnt_reg   <= per_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      dir_reg       <= dir_next;
      aborted_reg   <= aborted_next;
      stepmotor_reg <= stepmotor_next;
    end
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg == S_RUN) || (state_reg == S_HOLD);
  assign done      = (state_reg == S_DONE);
  assign state     = state_reg;
  assign stepmotor = stepmotor_reg;
  assign position  = position_reg;
  assign aborted   = aborted_reg;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer: directed moves from the test plan plus
// random moves, each compared cycle by cycle against a timeline model.
module tb_stepper_move_sequencer;

  localparam int H    = 3;
  localparam int MINP = 2;
`ifdef STEPPER_HALFSTEP_EN
  localparam int L = 8;
`else
  localparam int L = 4;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic [3:0]  stepmotor;
  logic [15:0] position;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [1:0]  state;

  logic [3:0] tbl [L];

  int total = 0;
  int bad   = 0;
  int idx_m = 0;
  int pos_m = 0;
  int ab_m  = 0;

  stepper_move_sequencer #(.HOLD_CYCLES(H), .MIN_PERIOD(MINP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .stepmotor(stepmotor), .position(position), .busy(busy),
    .done(done), .aborted(aborted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // One move, checked every cycle from the accept edge (t=0) back to IDLE.
  // abort_at > 0 raises abort so that the edge at offset abort_at sees it.
  task automatic run_move(input bit dir, input int steps, input int period,
                          input int abort_at, input bit keep_valid);
    int pe, run_len, done_nat, done_t, sd, m, pe_pos, es;
    logic [3:0] esm;
    pe       = (period < MINP) ? MINP : period;
    run_len  = (steps == 0) ? 1 : steps * pe;
    done_nat = (steps == 0) ? H + 2 : steps * pe + H;
    done_t   = (abort_at > 0) ? abort_at : done_nat;
    sd       = 0;
    wait_ready();
    cmd_dir    = dir;
    cmd_steps  = 16'(steps);
    cmd_period = 16'(period);
    cmd_valid  = 1'b1;
    tick();
    for (int t = 0; t <= done_t + 1; t++) begin
      if (abort_at > 0 && t >= abort_at) sd = (abort_at - 1) / pe;
      else sd = t / pe;
      if (sd > steps) sd = steps;
      if (t == done_t + 1)  es = 0;
      else if (t == done_t) es = 3;
      else if (t < run_len) es = 1;
      else es = 2;
      m = idx_m + (dir ? sd : -sd);
      m = ((m % L) + L) % L;
      esm = (es == 1 || es == 2) ? tbl[m] : 4'b0000;
      pe_pos = (pos_m + (dir ? sd : -sd)) & 32'hFFFF;
      check("state", 32'(state), 32'(es));
      check("stepmotor", 32'(stepmotor), 32'(esm));
      check("position", 32'(position), 32'(pe_pos));
      check("busy", 32'(busy), 32'(es == 1 || es == 2));
      check("done", 32'(done), 32'(es == 3));
      check("cmd_ready", 32'(cmd_ready), 32'(es == 0));
      check("aborted", 32'(aborted), 32'(abort_at > 0 && t >= abort_at));
      if (t == 0 && !keep_valid) begin
        cmd_valid  = 1'b0;
        cmd_dir    = 1'($urandom);
        cmd_steps  = 16'($urandom);
        cmd_period = 16'($urandom);
      end
      abort = (abort_at > 0 && t + 1 == abort_at);
      if (t < done_t + 1) tick();
    end
    abort = 1'b0;
    idx_m = ((idx_m + (dir ? sd : -sd)) % L + L) % L;
    pos_m = (pos_m + (dir ? sd : -sd)) & 32'hFFFF;
    ab_m  = (abort_at > 0) ? 1 : 0;
    $display("move dir=%0d steps=%0d period=%0d abort_at=%0d -> position=%0h phase=%0d",
             dir, steps, period, abort_at, pos_m, idx_m);
  endtask

  initial begin
`ifdef STEPPER_HALFSTEP_EN
    tbl = '{4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0001, 4'b1001, 4'b1000};
`else
    tbl = '{4'b1010, 4'b0110, 4'b0101, 4'b1001};
`endif
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = 16'd0;
    cmd_period = 16'd0;
    abort      = 1'b0;

    // Reset state
    #12;
    check("rst_stepmotor", 32'(stepmotor), 32'd0);
    check("rst_position", 32'(position), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    #10 rst = 1'b1;
    tick();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    $display("reset released");

    // Forward 5 steps, period 4: done 23 cycles after accept
    run_move(1'b1, 5, 4, 0, 1'b0);

    // Reset mid-move: outputs clear without a clock edge, phase returns to 0
    wait_ready();
    cmd_dir = 1'b1; cmd_steps = 16'd10; cmd_period = 16'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_stepmotor", 32'(stepmotor), 32'd0);
    check("midrst_position", 32'(position), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_aborted", 32'(aborted), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idx_m = 0; pos_m = 0; ab_m = 0;
    tick();
    $display("mid-move reset applied");

    // Reverse 3 steps from index 0: position ends at 0xFFFD
    run_move(1'b0, 3, 2, 0, 1'b0);
    check("rev_position", 32'(position), 32'h0000FFFD);

    // Periods 0 and 1 clamp to the minimum
    run_move(1'b1, 4, 0, 0, 1'b0);
    run_move(1'b1, 4, 1, 0, 1'b0);

    // Zero-step move
    run_move(1'b1, 0, 5, 0, 1'b0);

    // Abort on the 2nd step's expiry, command held valid through the move,
    // then the held command is taken once back in IDLE
    run_move(1'b1, 5, 3, 6, 1'b1);
    run_move(1'b1, 5, 3, 0, 1'b0);

    // Abort while idle is ignored
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_abort_state", 32'(state), 32'd0);
      check("idle_abort_flag", 32'(aborted), 32'(ab_m));
      check("idle_abort_pos", 32'(position), 32'(pos_m));
    end
    abort = 1'b0;
    $display("idle abort ignored");

    // Full table walk forward, and an abort during HOLD
    run_move(1'b1, 8, 2, 0, 1'b0);
    run_move(1'b0, 2, 2, 5, 1'b0);

    // Random moves
    for (int i = 0; i < 25; i++) begin
      int rs, rp, ra, dn;
      rs = $urandom_range(10, 0);
      rp = $urandom_range(5, 0);
      dn = (rs == 0) ? H + 2 : rs * ((rp < MINP) ? MINP : rp) + H;
      ra = ($urandom_range(3, 0) == 0) ? $urandom_range(dn, 1) : 0;
      run_move(1'($urandom), rs, rp, ra, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
